// File: rtl/debug_uart_pkg.sv
// Shared UART definitions: receiver state encoding and the default frame/baud
// constants used by the rx core, the tx side and the debugger.
package debug_uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    WAITHI = 3'd4,
    BRK    = 3'd5
  } rx_state_t;

  localparam int DBIT_DEF     = 8;
  localparam int SB_TICK_DEF  = 16;
  localparam int DVSR_DEF     = 326;   // 50 MHz / (16 * 9600)
  localparam int DVSR_BIT_DEF = 9;

endpackage

// File: rtl/uart_rx_core_if.sv
// Serial line in and byte/status out of the UART receiver.
// slave = receiver side, master = line driver / FIFO side.
interface uart_rx_core_if #(parameter int DBIT = 8);
  logic            i_rx;
  logic            o_rx_done;
  logic [DBIT-1:0] o_data;
  logic            o_frame_err;
  logic            o_break;
  logic            o_busy;

  modport slave  (input  i_rx,
                  output o_rx_done, o_data, o_frame_err, o_break, o_busy);
  modport master (output i_rx,
                  input  o_rx_done, o_data, o_frame_err, o_break, o_busy);
endinterface

// File: rtl/baud_tick_gen.sv
// Free-running mod-DVSR counter; tick is high for the single clk at DVSR-1.
module baud_tick_gen #(
  parameter int DVSR     = 326,
  parameter int DVSR_BIT = 9
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  logic [DVSR_BIT-1:0] cnt;

  assign tick = (cnt == DVSR_BIT'(DVSR - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + DVSR_BIT'(1);
  end
endmodule

// File: rtl/uart_rx_core.sv
// 16x oversampling 8N1-style UART receiver: deframes bytes, strobes good bytes
// for the RX FIFO, flags framing errors and holds a break level.
module uart_rx_core
  import debug_uart_pkg::*;
#(
  parameter int DBIT     = DBIT_DEF,
  parameter int SB_TICK  = SB_TICK_DEF,
  parameter int DVSR     = DVSR_DEF,
  parameter int DVSR_BIT = DVSR_BIT_DEF
) (
  input  logic            i_clk,
  input  logic            i_reset,
  uart_rx_core_if.slave   bus
);
  localparam int NW = $clog2(DBIT);

  rx_state_t       state, state_n;
  logic [4:0]      s, s_n;
  logic [NW-1:0]   n, n_n;
  logic [DBIT-1:0] b, b_n, data, data_n;
  logic            done, done_n, ferr, ferr_n, brk;
  logic            rx_q, rx_s, tick;

  baud_tick_gen #(.DVSR(DVSR), .DVSR_BIT(DVSR_BIT)) u_tick (
    .clk   (i_clk),
    .rst_n (i_reset),
    .tick  (tick)
  );

  // Idle-high synchroniser; raw i_rx is used nowhere else.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      rx_q <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_q <= bus.i_rx;
      rx_s <= rx_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state <= IDLE;
      s     <= '0;
      n     <= '0;
      b     <= '0;
      data  <= '0;
      done  <= 1'b0;
      ferr  <= 1'b0;
      brk   <= 1'b0;
    end else begin
      state <= state_n;
      s     <= s_n;
      n     <= n_n;
      b     <= b_n;
      data  <= data_n;
      done  <= done_n;
      ferr  <= ferr_n;
      brk   <= (state_n == BRK);
    end
  end

  always_comb begin
    state_n = state;
    s_n     = s;
    n_n     = n;
    b_n     = b;
    data_n  = data;
    done_n  = 1'b0;
    ferr_n  = 1'b0;
    case (state)
      IDLE: if (!rx_s) begin
        state_n = START;
        s_n     = '0;
      end
      // Mid-start recheck rejects short low glitches.
      START: if (tick) begin
        if (s == 5'd7) begin
          if (!rx_s) begin
            state_n = DATA;
            s_n     = '0;
            n_n     = '0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          s_n = s + 5'd1;
        end
      end
      DATA: if (tick) begin
        if (s == 5'd15) begin
          s_n = '0;
          b_n = {rx_s, b[DBIT-1:1]};
          if (n == NW'(DBIT - 1)) state_n = STOP;
          else                    n_n     = n + NW'(1);
        end else begin
          s_n = s + 5'd1;
        end
      end
      STOP: if (tick) begin
        if (s == 5'(SB_TICK - 1)) begin
          if (rx_s) begin
            data_n  = b;
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = (b == '0) ? BRK : WAITHI;
          end
        end else begin
          s_n = s + 5'd1;
        end
      end
      // Hold off until the line returns high so a stuck-low line cannot retrigger.
      WAITHI, BRK: if (rx_s) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign bus.o_rx_done   = done;
  assign bus.o_data      = data;
  assign bus.o_frame_err = ferr;
  assign bus.o_break     = brk;
  assign bus.o_busy      = (state != IDLE);
endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at DVSR=4 (64 clks per bit) with a strobe scoreboard.
module tb_uart_rx_core;
  localparam int BIT_CLKS = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } exp_t;
  exp_t exp_q[$];

  uart_rx_core_if #(.DBIT(8)) bus ();

  uart_rx_core #(.DBIT(8), .SB_TICK(16), .DVSR(4), .DVSR_BIT(3)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic wait_clks(input int c);
    repeat (c) @(negedge clk);
  endtask

  task automatic send_bit(input logic v);
    bus.i_rx = v;
    wait_clks(BIT_CLKS);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic expect_byte(input logic [7:0] d);
    exp_t e;
    e.is_err = 1'b0;
    e.data   = d;
    exp_q.push_back(e);
  endtask

  task automatic expect_ferr(input logic [7:0] held);
    exp_t e;
    e.is_err = 1'b1;
    e.data   = held;
    exp_q.push_back(e);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_data"},  32'(bus.o_data), 32'h0);
    chk({tag, "_busy"},  32'(bus.o_busy), 32'h0);
    chk({tag, "_break"}, 32'(bus.o_break), 32'h0);
    chk({tag, "_strb"},  32'({bus.o_rx_done, bus.o_frame_err}), 32'h0);
  endtask

  // Monitor: every strobe must match the oldest expected event.
  logic prev_done = 1'b0, prev_ferr = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.o_rx_done || bus.o_frame_err) begin
        chk("strobe_excl", 32'(bus.o_rx_done & bus.o_frame_err), 32'h0);
        chk("strobe_width", 32'((bus.o_rx_done & prev_done) | (bus.o_frame_err & prev_ferr)), 32'h0);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_strobe: done=%0b ferr=%0b data=%0h expected none",
                   bus.o_rx_done, bus.o_frame_err, bus.o_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("strobe_kind", 32'(bus.o_frame_err), 32'(e.is_err));
          chk("strobe_data", 32'(bus.o_data), 32'(e.data));
        end
      end
    end
    prev_done = bus.o_rx_done;
    prev_ferr = bus.o_frame_err;
  end

  initial begin
    bus.i_rx = 1'b1;
    wait_clks(5);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    wait_clks(100);

    // Good frame
    expect_byte(8'hA5);
    send_frame(8'hA5, 1'b1);
    wait_clks(20);
    chk("a5_busy_after", 32'(bus.o_busy), 32'h0);
    chk("a5_data", 32'(bus.o_data), 32'hA5);

    // 20-clk low glitch must be rejected at mid-start
    bus.i_rx = 1'b0;
    wait_clks(20);
    bus.i_rx = 1'b1;
    wait_clks(100);
    chk("glitch_busy", 32'(bus.o_busy), 32'h0);
    chk("glitch_data", 32'(bus.o_data), 32'hA5);

    // Framing error, nonzero payload -> WAITHI, no break
    expect_ferr(8'hA5);
    send_frame(8'h3C, 1'b0);
    wait_clks(BIT_CLKS);
    chk("ferr_busy_low_line", 32'(bus.o_busy), 32'h1);
    chk("ferr_no_break", 32'(bus.o_break), 32'h0);
    bus.i_rx = 1'b1;
    wait_clks(10);
    chk("ferr_busy_released", 32'(bus.o_busy), 32'h0);
    chk("ferr_data_held", 32'(bus.o_data), 32'hA5);
    wait_clks(100);

    // Line break: 20 bit times low
    expect_ferr(8'hA5);
    bus.i_rx = 1'b0;
    wait_clks(20 * BIT_CLKS);
    chk("break_level", 32'(bus.o_break), 32'h1);
    bus.i_rx = 1'b1;
    wait_clks(6);
    chk("break_cleared", 32'(bus.o_break), 32'h0);
    wait_clks(100);
    expect_byte(8'h55);
    send_frame(8'h55, 1'b1);
    wait_clks(20);
    chk("after_break_data", 32'(bus.o_data), 32'h55);

    // Back-to-back frames, no idle gap
    expect_byte(8'h00);
    expect_byte(8'hFF);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_clks(20);
    chk("b2b_data", 32'(bus.o_data), 32'hFF);
    wait_clks(100);

    // Reset during data bit 4 discards the partial frame
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    bus.i_rx = 1'b0;
    wait_clks(BIT_CLKS / 2);
    rst_n = 1'b0;
    wait_clks(1);
    chk_reset_outputs("midreset");
    bus.i_rx = 1'b1;
    wait_clks(10);
    rst_n = 1'b1;
    wait_clks(200);
    chk("postreset_busy", 32'(bus.o_busy), 32'h0);
    expect_byte(8'h81);
    send_frame(8'h81, 1'b1);
    wait_clks(100);
    chk("final_data", 32'(bus.o_data), 32'h81);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
